// File: rtl/imem_fetch_pkg.sv
// Shared constants, field positions and redirect decode for the instruction fetch unit.
package imem_fetch_pkg;

    localparam int unsigned INSTR_BITS = 16;

    typedef enum logic [1:0] {
        OP_R = 2'b00,
        OP_I = 2'b01,
        OP_B = 2'b10,
        OP_S = 2'b11
    } opcode_e;

    localparam logic [5:0]  CALL_TAG  = 6'b000000;
    localparam logic [5:0]  RET_TAG   = 6'b111111;
    localparam logic [2:0]  CALL_RS   = 3'b110;
    localparam logic [2:0]  RET_RS    = 3'b111;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_W   = 2;
    localparam int unsigned RS_LSB  = 2;
    localparam int unsigned RS_W    = 3;
    localparam int unsigned TGT_LSB = 5;
    localparam int unsigned TGT_W   = 5;
    localparam int unsigned TAG_LSB = 10;
    localparam int unsigned TAG_W   = 6;

    typedef enum logic [1:0] {
        DEC_SEQ,
        DEC_CALL,
        DEC_RET,
        DEC_HALT
    } dec_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_e;

    // Priority decode: halt beats return, since the halt word also matches the return pattern.
    function automatic dec_e decode(input logic [INSTR_BITS-1:0] w);
        logic [OPC_W-1:0] opc;
        logic [RS_W-1:0]  rs;
        logic [TAG_W-1:0] tag;
        opc = w[OPC_LSB +: OPC_W];
        rs  = w[RS_LSB +: RS_W];
        tag = w[TAG_LSB +: TAG_W];
        if (w == HALT_WORD)
            return DEC_HALT;
        else if (opc == OP_S && tag == RET_TAG && rs == RET_RS)
            return DEC_RET;
        else if (opc == OP_S && tag == CALL_TAG && rs == CALL_RS)
            return DEC_CALL;
        else
            return DEC_SEQ;
    endfunction

    function automatic logic [TGT_W-1:0] call_target(input logic [INSTR_BITS-1:0] w);
        return w[TGT_LSB +: TGT_W];
    endfunction

endpackage

// File: rtl/imem_fetch_ret_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ret_addr_stack #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top_c,
    output logic              empty_c,
    output logic              ovf_c,
    output logic              unf_c
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              full;

    assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty_c = (cnt_q == '0);
    assign top_c   = mem[ptr_q - PTR_W'(1)];
    assign ovf_c   = push & full;
    assign unf_c   = pop & empty_c;

    // Pointer wraps naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full)
                cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !empty_c) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr_q] <= din;
    end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch: owns the PC, registers fetched words and resolves call/return/branch/halt redirects.
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_adr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted,
    output logic               ras_err
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pcout_q, pcout_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic               en;
    dec_e               dec;
    logic [ADDR_W-1:0]  pc_inc;
    logic               push, pop;
    logic [ADDR_W-1:0]  ras_top;
    logic               ras_empty, ras_ovf, ras_unf;

    assign en     = rst && !stall && (state_q == ST_RUN);
    assign dec    = decode(INSTR_BITS'(imem_data));
    assign pc_inc = pc_q + ADDR_W'(1);
    assign push   = en && !br_taken && (dec == DEC_CALL);
    assign pop    = en && !br_taken && (dec == DEC_RET);
    assign err_d  = err_q | ras_ovf | ras_unf;

    ret_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .top_c   (ras_top),
        .empty_c (ras_empty),
        .ovf_c   (ras_ovf),
        .unf_c   (ras_unf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            pcout_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcout_q <= pcout_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: branch squash, then halt, call, return, sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pcout_d = pcout_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (en) begin
            instr_d = imem_data;
            pcout_d = pc_q;
            if (br_taken) begin
                pc_d    = br_target;
                valid_d = 1'b0;
            end else begin
                case (dec)
                    DEC_HALT: begin
                        state_d = ST_HALT;
                        valid_d = 1'b0;
                    end
                    DEC_CALL: begin
                        pc_d    = ADDR_W'(call_target(INSTR_BITS'(imem_data)));
                        valid_d = 1'b1;
                    end
                    DEC_RET: begin
                        pc_d    = ras_empty ? pc_inc : ras_top;
                        valid_d = 1'b1;
                    end
                    default: begin
                        pc_d    = pc_inc;
                        valid_d = 1'b1;
                    end
                endcase
            end
        end
    end

    assign imem_adr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pcout_q;
    assign halted      = (state_q == ST_HALT);
    assign ras_err     = err_q;

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Instruction fetch unit that sits between the processor core and the combinational instruction memory. It owns the program counter and drives the 5-bit instruction address. It registers the returned 16-bit word into an instruction register for decode. It resolves function call/return redirects locally through a small return-address stack, accepts branch redirects from execute, and halts on the all-ones halt word.

## Interface
Parameters:
- ADDR_W, 5: instruction address width; PC wraps modulo 2^ADDR_W
- INSTR_W, 16: instruction word width
- RAS_DEPTH, 4: return-address stack entries (power of two)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  1  core stall; freezes PC, IR, RAS, outputs
- br_taken  in  1  branch redirect from execute
- br_target  in  ADDR_W  branch destination
- imem_adr  out  ADDR_W  address to instruction memory (= PC, combinational from register)
- imem_data  in  INSTR_W  word from memory, valid same cycle as imem_adr
- instr  out  INSTR_W  registered instruction
- instr_valid  out  1  instr is a live, non-squashed instruction
- pc_out  out  ADDR_W  address instr was fetched from
- halted  out  1  halt word fetched; fetch frozen until reset
- ras_err  out  1  sticky: RAS overflow or underflow occurred

## Operation
- Decode of imem_data for redirect, checked in priority order:
  - halt: word == 16'hFFFF
  - return: [1:0]==2'b11, [15:10]==6'b111111, [4:2]==3'b111
  - call: [1:0]==2'b11, [15:10]==6'b000000, [4:2]==3'b110; target = [9:5]
  - all other words, including stores ([1:0]==11, [4:2]==000): sequential
- Per enabled cycle (rst=1, stall=0, halted=0): instr<=imem_data, pc_out<=PC, PC<=next.
- Next-PC priority:
  1. br_taken: PC<=br_target; fetched word loaded with instr_valid=0 (squash); no RAS change, no halt.
  2. halt: halted<=1, instr_valid<=0, PC holds.
  3. call: push PC+1 (mod 32), PC<=target, instr_valid<=1.
  4. return: pop, PC<=popped value, instr_valid<=1.
  5. otherwise: PC<=PC+1 (31 wraps to 0), instr_valid<=1.
- RAS full on call: overwrite oldest entry (circular); ras_err<=1.
- RAS empty on return: PC<=PC+1; pointer unchanged; ras_err<=1.
- stall=1: every register holds, including instr_valid, and br_taken is ignored; execute holds br_taken until stall drops.
- halted=1: br_taken, stall and imem_data are ignored; only reset exits.

## Timing
- Reset (rst=0 at an edge): PC=0, instr=0, pc_out=0, instr_valid=0, halted=0, ras_err=0, RAS pointer/count=0. imem_adr=0 during reset.
- Reset asserted mid-operation overrides everything at that edge, including stall, br_taken and halt.
- Fetch latency is 1 cycle: word at imem_adr in cycle N appears on instr in cycle N+1.
- First valid instruction (mem[0]) appears in the cycle after the first edge with rst=1.
- Call/return cost zero bubbles: the target is fetched in the cycle after the call or return word.
- Taken branch costs one bubble (the squashed wrong-path word). The target appears on instr 2 cycles after br_taken is sampled.
- Push and pop never occur in the same cycle; the decode is one-hot.

## Structure
- Package imem_fetch_pkg holds:
  - opcode constants OP_R=2'b00, OP_I=2'b01, OP_B=2'b10, OP_S=2'b11
  - CALL_TAG=6'b000000, RET_TAG=6'b111111, CALL_RS=3'b110, RET_RS=3'b111
  - HALT_WORD=16'hFFFF
  - field bit positions
- One sub-module, ret_addr_stack: circular stack with push/pop/full/empty and overflow/underflow flags, parameterised by RAS_DEPTH and ADDR_W.
- Memory model is external; the bench instantiates the existing instruction memory.

## Test plan
- Sequential fetch: program mem[0..3] with R-type words; release reset. Required: pc_out 0,1,2,3 on consecutive cycles, instr_valid=1 from the first cycle after release; after 32 fetches PC wraps 31→0.
- Call/return: mem[1]={000000,01010,110,11}, mem[10]=LDR, mem[11]={111111,01010,111,11}. Required: pc_out sequence 0,1,10,11,2 with no bubbles; RAS empty afterwards; ras_err=0.
- Branch squash: assert br_taken with br_target=5'd20 while PC=3. Required: next cycle instr_valid=0; the following cycle pc_out=20 with instr_valid=1.
- Stall plus branch: stall for 3 cycles with br_taken high. Required: instr and pc_out are frozen and the branch is not taken until the first cycle with stall=0.
- Halt and RAS errors: mem[2]=16'hFFFF; then, in a separate run, 5 nested calls followed by 6 returns. Required: halted=1 and PC frozen at 2 with instr_valid=0 until rst=0; ras_err set on the 5th call and held.
- Reset mid-run: drive rst=0 during a call cycle. Required: all outputs return to reset values at that edge, and the fetch restarts at mem[0].
